// File: rtl/hello_scroller.sv
// hello_scroller: scrolls a circular "HELLO" message across active-low 7-segment digits, auto (run) or stepped (pause)
module hello_scroller #(
  parameter int NUM_DIGITS = 5,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000,
  localparam int PW        = $clog2(MSG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [PW-1:0]           pos,
  output logic                    wrap
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [6:0] G_H = 7'b0001001;
  localparam logic [6:0] G_E = 7'b0000110;
  localparam logic [6:0] G_L = 7'b1000111;
  localparam logic [6:0] G_O = 7'b1000000;
  localparam logic [6:0] G_B = 7'b1111111;
  typedef enum logic {PAUSE, RUN} state_t;
  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    step_d;
  logic                    tick;
  logic                    adv;
  logic                    at_wrap;
  logic [PW-1:0]           pos_n;
  logic [7*NUM_DIGITS-1:0] hex_n;
  function automatic logic [6:0] glyph(input int i);
    return i == 0 ? G_H : i == 1 ? G_E : (i == 2 || i == 3) ? G_L : i == 4 ? G_O : G_B;
  endfunction
  assign tick    = state == RUN && cnt == CW'(TICK_DIV - 1);
  assign adv     = tick || (state == PAUSE && step && !step_d);
  assign at_wrap = dir ? pos == '0 : pos == PW'(MSG_LEN - 1);
  assign pos_n   = at_wrap ? (dir ? PW'(MSG_LEN - 1) : '0) : (dir ? pos - PW'(1) : pos + PW'(1));
  // pos < MSG_LEN and NUM_DIGITS <= MSG_LEN, so one conditional subtract is a full modulo
  always_comb begin
    hex_n = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      int idx;
      idx = int'(pos) + NUM_DIGITS - 1 - k;
      idx = idx >= MSG_LEN ? idx - MSG_LEN : idx;
      hex_n[7*k +: 7] = glyph(idx);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PAUSE;
      cnt    <= '0;
      step_d <= 1'b0;
      pos    <= '0;
      wrap   <= 1'b0;
      hex    <= '1;
    end else begin
      state  <= run ? RUN : PAUSE;
      cnt    <= (state == PAUSE || tick) ? '0 : cnt + CW'(1);
      step_d <= step;
      wrap   <= adv && at_wrap;
      hex    <= hex_n;
      if (adv) pos <= pos_n;
    end
  end
endmodule

// File: tb/tb_hello_scroller.sv
// tb_hello_scroller: scoreboard bench for hello_scroller with directed scroll, step, and reset vectors
module tb_hello_scroller;
  localparam logic [6:0] H = 7'b0001001;
  localparam logic [6:0] E = 7'b0000110;
  localparam logic [6:0] L = 7'b1000111;
  localparam logic [6:0] O = 7'b1000000;
  localparam logic [6:0] B = 7'b1111111;
  localparam logic [34:0] HX0 = {H, E, L, L, O};
  localparam logic [34:0] HX1 = {E, L, L, O, B};
  localparam logic [34:0] HX7 = {B, H, E, L, L};
  typedef struct {
    logic [2:0]  p;
    logic        w;
    logic [34:0] h;
    int          c;
  } exp_t;
  logic        clk = 0;
  logic        rst = 1;
  logic        run = 0;
  logic        dir = 0;
  logic        step = 0;
  logic [34:0] hex;
  logic [2:0]  pos;
  logic        wrap;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [6:0]  bm[8] = '{H, E, L, L, O, B, B, B};
  hello_scroller #(.NUM_DIGITS(5), .MSG_LEN(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .step(step),
    .hex(hex), .pos(pos), .wrap(wrap)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [34:0] exp_hex(input int p);
    logic [34:0] r;
    for (int k = 0; k < 5; k++) r[7*k +: 7] = bm[(p + 4 - k) % 8];
    return r;
  endfunction
  task automatic push(input int p, input logic w, input int c, input logic [34:0] h);
    exp_t e;
    e.p = 3'(p);
    e.w = w;
    e.c = c;
    e.h = h;
    q.push_back(e);
  endtask
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask
  logic [2:0]  last_pos = 0;
  logic        pend = 0;
  logic [34:0] pend_hex;
  always @(negedge clk) begin
    if (rst) begin
      last_pos = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("hex_after_step", 64'(hex), 64'(pend_hex));
        pend = 0;
      end
      if (pos != last_pos || wrap) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_advance: pos %0d wrap %0b, was %0d (cycle %0d)", pos, wrap, last_pos, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pos", 64'(pos), 64'(e.p));
          chk("wrap", 64'(wrap), 64'(e.w));
          chk("step_cycle", 64'(cyc), 64'(e.c));
          pend_hex = e.h;
          pend = 1;
        end
      end
      last_pos = pos;
    end
  end
  initial begin
    int n;
    wait_cyc(2);
    chk("reset_hex", 64'(hex), 64'h7_FFFF_FFFF);
    chk("reset_pos", 64'(pos), 0);
    chk("reset_wrap", 64'(wrap), 0);
    rst = 0;
    n = cyc;
    wait_cyc(n + 1);
    chk("hello_hex", 64'(hex), 64'(HX0));
    chk("hello_pos", 64'(pos), 0);
    n = cyc;
    run = 1;
    for (int i = 1; i <= 8; i++)
      push(i % 8, i == 8, n + 1 + 4 * i, i == 1 ? HX1 : i == 8 ? HX0 : exp_hex(i % 8));
    wait_cyc(n + 33);
    dir = 1;
    push(7, 1, n + 37, HX7);
    wait_cyc(n + 37);
    run = 0;
    dir = 0;
    wait_cyc(cyc + 2);
    n = cyc;
    step = 1;
    push(0, 1, n + 1, HX0);
    wait_cyc(n + 10);
    step = 0;
    wait_cyc(cyc + 2);
    for (int i = 1; i <= 3; i++) begin
      n = cyc;
      step = 1;
      push(i, 0, n + 1, exp_hex(i));
      wait_cyc(n + 1);
      step = 0;
      wait_cyc(n + 3);
    end
    chk("three_pulses_pos", 64'(pos), 3);
    n = cyc;
    run = 1;
    push(4, 0, n + 5, exp_hex(4));
    wait_cyc(n + 4);
    run = 0;
    wait_cyc(n + 25);
    chk("after_run_drop_pos", 64'(pos), 4);
    n = cyc;
    run = 1;
    step = 1;
    push(5, 0, n + 1, exp_hex(5));
    push(6, 0, n + 5, exp_hex(6));
    wait_cyc(n + 1);
    step = 0;
    wait_cyc(n + 5);
    run = 0;
    wait_cyc(n + 8);
    dir = 1;
    n = cyc;
    run = 1;
    push(5, 0, n + 5, exp_hex(5));
    wait_cyc(n + 6);
    rst = 1;
    wait_cyc(n + 7);
    chk("midrun_reset_pos", 64'(pos), 0);
    chk("midrun_reset_hex", 64'(hex), 64'h7_FFFF_FFFF);
    chk("midrun_reset_wrap", 64'(wrap), 0);
    wait_cyc(n + 8);
    run = 0;
    rst = 0;
    wait_cyc(n + 9);
    chk("post_reset_hex", 64'(hex), 64'(HX0));
    wait_cyc(n + 30);
    chk("post_reset_pos", 64'(pos), 0);
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
